// File: rtl/snoop_responder.sv
// snoop_responder
//   Bus-snoop responder for a set-associative cache directory of
//   2^INDEX_W sets x WAYS entries, each holding {tag, MESI state}.
//   A snoop is accepted in IDLE, looked up in LOOKUP, answered in RESPOND
//   (one-cycle resp_valid strobe plus the directory state change), and on
//   HITM the responder holds a write-back request in WB_WAIT until wb_ack.
//   Local fills may write one directory entry at any edge.
//
//   Optional feature macro: SNOOP_STATS_EN builds saturating 16-bit HIT and
//   HITM response counters; without it stat_hit/stat_hitm are tied to 0.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   snp_valid/snp_ready        snoop handshake
//   snp_op                     00 READ, 01 WRITE, 10 RWIM, 11 INVALIDATE
//   snp_index/snp_tag          snooped address
//   fill_*                     local directory install/update (MESI I/S/E/M = 0..3)
//   resp_valid/resp_result     response strobe; 00 HIT, 01 HITM, 10 NOHIT
//   wb_req/wb_index/wb_tag     pending write-back of a modified line
//   wb_ack                     write-back accepted
//   stat_hit/stat_hitm         response event counters

`timescale 1ns/1ps

`ifndef INDEX_SIZE
`define INDEX_SIZE 4
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 12
`endif

module snoop_responder #(
  parameter int unsigned INDEX_W = `INDEX_SIZE,
  parameter int unsigned TAG_W   = `TAG_SIZE,
  parameter int unsigned WAYS    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               snp_valid,
  output logic               snp_ready,
  input  logic [1:0]         snp_op,
  input  logic [INDEX_W-1:0] snp_index,
  input  logic [TAG_W-1:0]   snp_tag,
  input  logic               fill_valid,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [1:0]         fill_way,
  input  logic [1:0]         fill_mesi,
  output logic               resp_valid,
  output logic [1:0]         resp_result,
  output logic               wb_req,
  output logic [INDEX_W-1:0] wb_index,
  output logic [TAG_W-1:0]   wb_tag,
  input  logic               wb_ack,
  output logic [15:0]        stat_hit,
  output logic [15:0]        stat_hitm
);

  localparam int unsigned SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESPOND, ST_WB_WAIT} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RWIM, OP_INVAL} op_e;
  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_e;
  typedef enum logic [1:0] {RESP_HIT, RESP_HITM, RESP_NOHIT} resp_e;

  // Directory storage
  logic [TAG_W-1:0] dir_tag_q  [SETS][WAYS];
  logic [1:0]       dir_mesi_q [SETS][WAYS];

  // FSM and captured snoop
  state_e             state_q;
  logic               ready_q;
  logic [1:0]         op_q;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   snp_tag_q;
  logic               match_q;
  logic [1:0]         way_q;
  logic [1:0]         mstate_q;

  // Registered outputs
  logic               resp_valid_q;
  logic [1:0]         resp_result_q;
  logic               wb_req_q;
  logic [INDEX_W-1:0] wb_index_q;
  logic [TAG_W-1:0]   wb_tag_q;

  // Lookup / respond combinational results
  logic [TAG_W-1:0] eff_tag  [WAYS];
  logic [1:0]       eff_mesi [WAYS];
  logic             match_d;
  logic [1:0]       way_d;
  logic [1:0]       mstate_d;
  logic [1:0]       result_d;
  logic [1:0]       upd_mesi;
  logic             resp_update;
  logic             fill_in_range;

  assign fill_in_range = ({30'b0, fill_way} < WAYS);

  // A fill landing on the looked-up set at the LOOKUP edge is forwarded so
  // the comparison sees the new entry rather than the stale array content.
  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      eff_tag[w]  = dir_tag_q[idx_q][2'(w)];
      eff_mesi[w] = dir_mesi_q[idx_q][2'(w)];
      if (fill_valid && (fill_index == idx_q) && ({30'b0, fill_way} == w)) begin
        eff_tag[w]  = fill_tag;
        eff_mesi[w] = fill_mesi;
      end
    end
  end

  // First matching way in ascending order wins.
  always_comb begin
    match_d  = 1'b0;
    way_d    = '0;
    mstate_d = MESI_I;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!match_d && (eff_mesi[w] != MESI_I) && (eff_tag[w] == snp_tag_q)) begin
        match_d  = 1'b1;
        way_d    = 2'(w);
        mstate_d = eff_mesi[w];
      end
    end
  end

  always_comb begin
    result_d = RESP_NOHIT;
    upd_mesi = mstate_q;
    if (match_q && (op_q != OP_WRITE)) begin
      result_d = (mstate_q == MESI_M) ? RESP_HITM : RESP_HIT;
      upd_mesi = (op_q == OP_READ) ? MESI_S : MESI_I;
    end
  end

  assign resp_update = (state_q == ST_RESPOND) && match_q && (op_q != OP_WRITE);

  always_ff @(posedge clk) begin
    if (fill_valid && fill_in_range) begin
      dir_tag_q[fill_index][fill_way] <= fill_tag;
    end
  end

  // The fill write follows the snoop update so a same-entry fill wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          dir_mesi_q[INDEX_W'(s)][2'(w)] <= MESI_I;
        end
      end
    end else begin
      if (resp_update) begin
        dir_mesi_q[idx_q][way_q] <= upd_mesi;
      end
      if (fill_valid && fill_in_range) begin
        dir_mesi_q[fill_index][fill_way] <= fill_mesi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b0;
      op_q          <= '0;
      idx_q         <= '0;
      snp_tag_q     <= '0;
      match_q       <= 1'b0;
      way_q         <= '0;
      mstate_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      wb_req_q      <= 1'b0;
      wb_index_q    <= '0;
      wb_tag_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (snp_valid && ready_q) begin
            op_q      <= snp_op;
            idx_q     <= snp_index;
            snp_tag_q <= snp_tag;
            ready_q   <= 1'b0;
            state_q   <= ST_LOOKUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          match_q  <= match_d;
          way_q    <= way_d;
          mstate_q <= mstate_d;
          state_q  <= ST_RESPOND;
        end
        ST_RESPOND: begin
          resp_valid_q  <= 1'b1;
          resp_result_q <= result_d;
          if (result_d == RESP_HITM) begin
            wb_req_q   <= 1'b1;
            wb_index_q <= idx_q;
            wb_tag_q   <= snp_tag_q;
            state_q    <= ST_WB_WAIT;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WB_WAIT: begin
          if (wb_ack) begin
            wb_req_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign snp_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign wb_req      = wb_req_q;
  assign wb_index    = wb_index_q;
  assign wb_tag      = wb_tag_q;

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_hit_q;
  logic [15:0] stat_hitm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hit_q  <= '0;
      stat_hitm_q <= '0;
    end else if (state_q == ST_RESPOND) begin
      if ((result_d == RESP_HIT) && (stat_hit_q != '1)) begin
        stat_hit_q <= stat_hit_q + 16'd1;
      end
      if ((result_d == RESP_HITM) && (stat_hitm_q != '1)) begin
        stat_hitm_q <= stat_hitm_q + 16'd1;
      end
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_hitm = stat_hitm_q;
`else
  assign stat_hit  = '0;
  assign stat_hitm = '0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder
//   Randomized and directed stimulus for snoop_responder, checked against a
//   behavioural directory model (plain arrays + MESI rules) kept here.

`timescale 1ns/1ps

module tb_snoop_responder;

    localparam int IW = 4;
    localparam int TW = 12;
    localparam int NW = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RWIM  = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    localparam logic [1:0] MI = 2'b00;
    localparam logic [1:0] MS = 2'b01;
    localparam logic [1:0] ME = 2'b10;
    localparam logic [1:0] MM = 2'b11;

    localparam logic [1:0] R_HIT   = 2'b00;
    localparam logic [1:0] R_HITM  = 2'b01;
    localparam logic [1:0] R_NOHIT = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snp_valid = 1'b0;
    logic          snp_ready;
    logic [1:0]    snp_op = '0;
    logic [IW-1:0] snp_index = '0;
    logic [TW-1:0] snp_tag = '0;
    logic          fill_valid = 1'b0;
    logic [IW-1:0] fill_index = '0;
    logic [TW-1:0] fill_tag = '0;
    logic [1:0]    fill_way = '0;
    logic [1:0]    fill_mesi = '0;
    logic          resp_valid;
    logic [1:0]    resp_result;
    logic          wb_req;
    logic [IW-1:0] wb_index;
    logic [TW-1:0] wb_tag;
    logic          wb_ack = 1'b0;
    logic [15:0]   stat_hit;
    logic [15:0]   stat_hitm;

    snoop_responder #(.INDEX_W(IW), .TAG_W(TW), .WAYS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op),
        .snp_index(snp_index), .snp_tag(snp_tag),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_way(fill_way), .fill_mesi(fill_mesi),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .wb_req(wb_req), .wb_index(wb_index), .wb_tag(wb_tag), .wb_ack(wb_ack),
        .stat_hit(stat_hit), .stat_hitm(stat_hitm)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference directory
    logic [TW-1:0] m_tag  [1<<IW][NW];
    logic [1:0]    m_mesi [1<<IW][NW];
    int unsigned   m_hit  = 0;
    int unsigned   m_hitm = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < (1 << IW); s++)
            for (int w = 0; w < NW; w++) begin
                m_mesi[s][w] = MI;
                m_tag[s][w]  = '0;
            end
        m_hit  = 0;
        m_hitm = 0;
    endfunction

    function automatic void model_fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                       input logic [1:0] way, input logic [1:0] mesi);
        m_tag[idx][way]  = tag;
        m_mesi[idx][way] = mesi;
    endfunction

    // Snoop rules: lowest matching way answers; WRITE never hits.
    function automatic logic [1:0] model_snoop(input logic [1:0] op, input logic [IW-1:0] idx,
                                               input logic [TW-1:0] tag);
        int hw = -1;
        logic [1:0] res;
        for (int w = NW - 1; w >= 0; w--)
            if (m_mesi[idx][w] != MI && m_tag[idx][w] == tag) hw = w;
        if (op == OP_WRITE || hw < 0) return R_NOHIT;
        res = (m_mesi[idx][hw] == MM) ? R_HITM : R_HIT;
        m_mesi[idx][hw] = (op == OP_READ) ? MS : MI;
        if (res == R_HIT && m_hit < 32'hFFFF) m_hit++;
        if (res == R_HITM && m_hitm < 32'hFFFF) m_hitm++;
        return res;
    endfunction

    function automatic logic [31:0] exp_hit();
`ifdef SNOOP_STATS_EN
        return m_hit;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] exp_hitm();
`ifdef SNOOP_STATS_EN
        return m_hitm;
`else
        return 0;
`endif
    endfunction

    task automatic check_set(input string tag, input logic [IW-1:0] idx);
        for (int w = 0; w < NW; w++)
            check(tag, {30'b0, dut.dir_mesi_q[idx][w]}, {30'b0, m_mesi[idx][w]});
    endtask

    task automatic check_all_invalid(input string tag);
        int cnt = 0;
        for (int s = 0; s < (1 << IW); s++)
            for (int w = 0; w < NW; w++)
                if (dut.dir_mesi_q[s][w] !== MI) cnt++;
        check(tag, cnt, 0);
    endtask

    task automatic do_fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [1:0] way, input logic [1:0] mesi);
        fill_valid = 1'b1; fill_index = idx; fill_tag = tag; fill_way = way; fill_mesi = mesi;
        tick();
        fill_valid = 1'b0;
        model_fill(idx, tag, way, mesi);
    endtask

    task automatic drive_fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              input logic [1:0] way, input logic [1:0] mesi);
        fill_valid = 1'b1; fill_index = idx; fill_tag = tag; fill_way = way; fill_mesi = mesi;
    endtask

    // fill_at: 0 none, 1 handshake edge, 2 LOOKUP edge, 3 RESPOND edge.
    // ack_delay < 0: reset is applied during WB_WAIT instead of acking.
    task automatic do_snoop(input logic [1:0] op, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input int fill_at, input logic [IW-1:0] f_idx, input logic [TW-1:0] f_tag,
                            input logic [1:0] f_way, input logic [1:0] f_mesi, input int ack_delay);
        logic [1:0] exp_res;
        int waited = 0;
        while (snp_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_before_snoop", {31'b0, snp_ready}, 1);
        snp_valid = 1'b1; snp_op = op; snp_index = idx; snp_tag = tag;
        if (fill_at == 1) drive_fill(f_idx, f_tag, f_way, f_mesi);
        tick();
        snp_valid = 1'b0;
        fill_valid = 1'b0;
        if (fill_at == 1) model_fill(f_idx, f_tag, f_way, f_mesi);
        check("ready_busy", {31'b0, snp_ready}, 0);
        if (fill_at == 2) drive_fill(f_idx, f_tag, f_way, f_mesi);
        tick();
        fill_valid = 1'b0;
        if (fill_at == 2) model_fill(f_idx, f_tag, f_way, f_mesi);
        check("resp_early", {31'b0, resp_valid}, 0);
        exp_res = model_snoop(op, idx, tag);
        if (fill_at == 3) drive_fill(f_idx, f_tag, f_way, f_mesi);
        tick();
        fill_valid = 1'b0;
        if (fill_at == 3) model_fill(f_idx, f_tag, f_way, f_mesi);
        check("resp_valid", {31'b0, resp_valid}, 1);
        check("resp_result", {30'b0, resp_result}, {30'b0, exp_res});
        check("stat_hit", {16'b0, stat_hit}, exp_hit());
        check("stat_hitm", {16'b0, stat_hitm}, exp_hitm());
        if (exp_res == R_HITM) begin
            check("wb_req_set", {31'b0, wb_req}, 1);
            check("wb_index", {28'b0, wb_index}, {28'b0, idx});
            check("wb_tag", {20'b0, wb_tag}, {20'b0, tag});
            check("ready_wb", {31'b0, snp_ready}, 0);
            if (ack_delay < 0) begin
                tick();
                check("wb_hold_pre_rst", {31'b0, wb_req}, 1);
                rst_n = 1'b0;
                tick();
                model_reset();
                check("rst_wb_req", {31'b0, wb_req}, 0);
                check("rst_resp_valid", {31'b0, resp_valid}, 0);
                check("rst_resp_result", {30'b0, resp_result}, 0);
                check("rst_wb_index", {28'b0, wb_index}, 0);
                check("rst_wb_tag", {20'b0, wb_tag}, 0);
                check("rst_stat_hitm", {16'b0, stat_hitm}, 0);
                check_all_invalid("rst_dir_invalid");
                rst_n = 1'b1;
                tick();
                check("ready_after_rst", {31'b0, snp_ready}, 1);
            end else begin
                for (int i = 0; i < ack_delay; i++) begin
                    tick();
                    check("wb_hold", {31'b0, wb_req}, 1);
                    check("wb_hold_tag", {20'b0, wb_tag}, {20'b0, tag});
                    check("ready_wb_hold", {31'b0, snp_ready}, 0);
                end
                wb_ack = 1'b1;
                tick();
                wb_ack = 1'b0;
                check("wb_req_drop", {31'b0, wb_req}, 0);
                check("ready_after_ack", {31'b0, snp_ready}, 1);
            end
        end else begin
            check("wb_req_idle", {31'b0, wb_req}, 0);
            check("ready_after_resp", {31'b0, snp_ready}, 1);
            tick();
            check("resp_pulse_end", {31'b0, resp_valid}, 0);
        end
        check_set("dir_snoop_set", idx);
        if (fill_at != 0) check_set("dir_fill_set", f_idx);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] pool [4];
        pool[0] = 12'h100; pool[1] = 12'h101; pool[2] = 12'h102; pool[3] = 12'h103;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst0_resp_valid", {31'b0, resp_valid}, 0);
        check("rst0_wb_req", {31'b0, wb_req}, 0);
        check("rst0_resp_result", {30'b0, resp_result}, 0);
        check("rst0_wb_index", {28'b0, wb_index}, 0);
        check("rst0_wb_tag", {20'b0, wb_tag}, 0);
        check("rst0_stat_hit", {16'b0, stat_hit}, 0);
        check("rst0_stat_hitm", {16'b0, stat_hitm}, 0);
        check_all_invalid("rst0_dir_invalid");
        rst_n = 1'b1;
        tick();
        check("rst0_ready", {31'b0, snp_ready}, 1);

        // READ on E -> HIT, E becomes S
        do_fill(4'd0, 12'h111, 2'd2, ME);
        do_snoop(OP_READ, 4'd0, 12'h111, 0, '0, '0, '0, '0, 0);
        check("read_e_to_s", {30'b0, dut.dir_mesi_q[0][2]}, {30'b0, MS});

        // RWIM on M -> HITM, ack held back 5 cycles, entry invalidated
        do_fill(4'd3, 12'hABC, 2'd1, MM);
        do_snoop(OP_RWIM, 4'd3, 12'hABC, 0, '0, '0, '0, '0, 5);
        check("rwim_m_to_i", {30'b0, dut.dir_mesi_q[3][1]}, {30'b0, MI});

        // NOHIT cases: unmatched tag, WRITE on S
        do_snoop(OP_READ, 4'd0, 12'h222, 0, '0, '0, '0, '0, 0);
        do_snoop(OP_WRITE, 4'd0, 12'h111, 0, '0, '0, '0, '0, 0);
        check("write_keeps_s", {30'b0, dut.dir_mesi_q[0][2]}, {30'b0, MS});

        // Fill at RESPOND edge wins over INVALIDATE update
        do_fill(4'd9, 12'h333, 2'd0, MS);
        do_snoop(OP_INVAL, 4'd9, 12'h333, 3, 4'd9, 12'h333, 2'd0, ME, 0);
        check("fill_wins", {30'b0, dut.dir_mesi_q[9][0]}, {30'b0, ME});

        // Fill at LOOKUP edge is visible to that lookup
        do_snoop(OP_READ, 4'd10, 12'h444, 2, 4'd10, 12'h444, 2'd3, MM, 0);

        // Multiple matching ways resolve to the lowest
        do_fill(4'd11, 12'h555, 2'd3, MM);
        do_fill(4'd11, 12'h555, 2'd1, MS);
        do_snoop(OP_RWIM, 4'd11, 12'h555, 0, '0, '0, '0, '0, 0);
        do_snoop(OP_READ, 4'd11, 12'h555, 0, '0, '0, '0, '0, 1);

        // Stray wb_ack while no write-back is pending
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("stray_ack_wb_req", {31'b0, wb_req}, 0);
        check("stray_ack_ready", {31'b0, snp_ready}, 1);

        // Randomized traffic over a small address/tag pool
        for (int it = 0; it < 150; it++) begin
            int nf;
            nf = int'($urandom_range(0, 2));
            for (int k = 0; k < nf; k++)
                do_fill(4'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                wb_ack = 1'b1;
                tick();
                wb_ack = 1'b0;
                check("rand_stray_ack", {31'b0, wb_req}, 0);
            end
            do_snoop(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
                     int'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset during WB_WAIT, then 2 HITs and 1 HITM from a clean start
        do_fill(4'd5, 12'h777, 2'd0, MM);
        do_snoop(OP_READ, 4'd5, 12'h777, 0, '0, '0, '0, '0, -1);
        do_fill(4'd6, 12'h010, 2'd0, ME);
        do_fill(4'd6, 12'h020, 2'd1, MS);
        do_fill(4'd6, 12'h030, 2'd2, MM);
        do_snoop(OP_READ, 4'd6, 12'h010, 0, '0, '0, '0, '0, 0);
        do_snoop(OP_INVAL, 4'd6, 12'h020, 0, '0, '0, '0, '0, 0);
        do_snoop(OP_RWIM, 4'd6, 12'h030, 0, '0, '0, '0, '0, 2);
        check("final_stat_hit", {16'b0, stat_hit}, exp_hit());
        check("final_stat_hitm", {16'b0, stat_hitm}, exp_hitm());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
